// File: rtl/rv32_fetch.sv
// Instruction fetch stage: owns the fetch PC, issues in-order word requests under
// a credit limit and buffers returned words with their PCs for the decoder.
module rv32_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        halt,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic        fetch_misaligned
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] ZERO_C  = {CW{1'b0}};
  localparam logic [CW:0]   DEPTH_C = (CW+1)'(DEPTH);

  typedef enum logic [0:0] {RUN = 1'b0, HOLD = 1'b1} state_e;

  state_e        state_q;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]   fifo_instr_q [DEPTH];
  logic [31:0]   fifo_pc_q    [DEPTH];
  logic          misaligned_q, misaligned_d;
  logic [CW:0]   credit_s;
  logic          issue_s, fire_s, drop_s, push_s, pop_s;

  // Handshake qualification and next-state; a redirect overrides issue, push and pop.
  always_comb begin
    credit_s     = {1'b0, inflight_q} + {1'b0, count_q};
    issue_s      = (state_q == RUN) && !rst && !halt && !redirect_valid && (credit_s < DEPTH_C);
    fire_s       = issue_s && imem_req_ready;
    drop_s       = imem_resp_valid && (drop_cnt_q != ZERO_C);
    push_s       = imem_resp_valid && (drop_cnt_q == ZERO_C) && !redirect_valid;
    pop_s        = (count_q != ZERO_C) && instr_ready && !redirect_valid;
    misaligned_d = redirect_valid && (redirect_pc[1:0] != 2'b00);
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      resp_pc_d  = {redirect_pc[31:2], 2'b00};
      // Every outstanding request belongs to the old path; one arriving now dies here.
      inflight_d = inflight_q - CW'(imem_resp_valid);
      drop_cnt_d = inflight_q - CW'(imem_resp_valid);
      count_d    = ZERO_C;
      wr_ptr_d   = {AW{1'b0}};
      rd_ptr_d   = {AW{1'b0}};
    end else begin
      fetch_pc_d = fire_s ? (fetch_pc_q + 32'd4) : fetch_pc_q;
      resp_pc_d  = push_s ? (resp_pc_q + 32'd4) : resp_pc_q;
      inflight_d = inflight_q + CW'(fire_s) - CW'(imem_resp_valid);
      drop_cnt_d = drop_cnt_q - CW'(drop_s);
      count_d    = count_q + CW'(push_s) - CW'(pop_s);
      wr_ptr_d   = wr_ptr_q + AW'(push_s);
      rd_ptr_d   = rd_ptr_q + AW'(pop_s);
    end
  end

  // Run/hold FSM, PCs, credit counters and FIFO storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      fetch_pc_q   <= RESET_PC;
      resp_pc_q    <= RESET_PC;
      inflight_q   <= ZERO_C;
      drop_cnt_q   <= ZERO_C;
      count_q      <= ZERO_C;
      wr_ptr_q     <= {AW{1'b0}};
      rd_ptr_q     <= {AW{1'b0}};
      misaligned_q <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_instr_q[i] <= 32'h0000_0000;
        fifo_pc_q[i]    <= 32'h0000_0000;
      end
    end else begin
      case (state_q)
        RUN:     state_q <= halt ? HOLD : RUN;
        HOLD:    state_q <= halt ? HOLD : RUN;
        default: state_q <= RUN;
      endcase
      fetch_pc_q   <= fetch_pc_d;
      resp_pc_q    <= resp_pc_d;
      inflight_q   <= inflight_d;
      drop_cnt_q   <= drop_cnt_d;
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      misaligned_q <= misaligned_d;
      if (push_s) begin
        fifo_instr_q[wr_ptr_q] <= imem_resp_data;
        fifo_pc_q[wr_ptr_q]    <= resp_pc_q;
      end
    end
  end

  assign imem_req_valid   = issue_s;
  assign imem_addr        = fetch_pc_q;
  assign instr_valid      = (count_q != ZERO_C);
  assign instr            = fifo_instr_q[rd_ptr_q];
  assign pc               = fifo_pc_q[rd_ptr_q];
  assign fetch_misaligned = misaligned_q;

endmodule

// File: tb/tb_rv32_fetch.sv
// Bench for rv32_fetch: directed scenarios plus a randomized run compared each
// cycle against a transaction-level model (epoch-tagged requests, expected stream).
`timescale 1ns/1ps
module tb_rv32_fetch;
  localparam logic [31:0] RST_PC  = 32'h0000_0100;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;
  localparam int          DEPTH   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1, halt = 1'b0, redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req_valid, imem_req_ready = 1'b1;
  logic [31:0] imem_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'h0;
  logic        instr_valid, instr_ready = 1'b1, fetch_misaligned;
  logic [31:0] instr, pc;

  rv32_fetch #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .halt(halt),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .pc(pc),
    .fetch_misaligned(fetch_misaligned)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;
  int p_ready = 100, lat_min = 1, lat_max = 1, last_due = 0;

  // Memory: outstanding requests, in order, with the model's view of each.
  logic [31:0] pend_addr[$], pend_mpc[$];
  int          pend_due[$], pend_ep[$];
  // Model: expected decoder-side stream and next expected fetch address.
  logic [31:0] exp_q_pc[$], exp_q_data[$];
  logic [31:0] next_addr = RST_PC;
  int          cur_ep = 0;
  logic        prev_halt = 1'b0, mis_pend = 1'b0;

  logic        obs_req_valid, obs_ivalid, obs_mis, obs_fire, obs_pop;
  logic [31:0] obs_addr, obs_instr, obs_pc;
  logic        exp_req_valid, exp_ivalid, exp_mis;
  logic [31:0] exp_addr, exp_pc, exp_instr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // One clock cycle: drive memory, sample at negedge, predict, advance the model.
  task automatic step();
    logic [31:0] m;
    int ep, due;
    logic keep;
    imem_req_ready = (int'($urandom_range(99)) < p_ready);
    if (!rst && pend_addr.size() > 0 && pend_due[0] <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(pend_addr[0]);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom;
    end
    @(negedge clk);
    obs_req_valid = imem_req_valid; obs_addr = imem_addr;
    obs_ivalid = instr_valid; obs_instr = instr; obs_pc = pc; obs_mis = fetch_misaligned;
    obs_fire = obs_req_valid && imem_req_ready;
    obs_pop  = obs_ivalid && instr_ready;
    exp_req_valid = !rst && !prev_halt && !halt && !redirect_valid &&
                    (pend_addr.size() + exp_q_pc.size() < DEPTH);
    exp_addr   = next_addr;
    exp_ivalid = (exp_q_pc.size() != 0);
    exp_pc = 32'h0; exp_instr = 32'h0;
    if (exp_ivalid) begin exp_pc = exp_q_pc[0]; exp_instr = exp_q_data[0]; end
    exp_mis = mis_pend;
    if (rst) begin
      pend_addr.delete(); pend_mpc.delete(); pend_due.delete(); pend_ep.delete();
      exp_q_pc.delete(); exp_q_data.delete();
      next_addr = RST_PC; prev_halt = 1'b0; mis_pend = 1'b0; last_due = 0;
    end else begin
      keep = 1'b0; m = 32'h0;
      if (imem_resp_valid) begin
        void'(pend_addr.pop_front()); void'(pend_due.pop_front());
        m = pend_mpc.pop_front(); ep = pend_ep.pop_front();
        keep = (ep == cur_ep) && !redirect_valid;
      end
      if (exp_ivalid && instr_ready && !redirect_valid) begin
        void'(exp_q_pc.pop_front()); void'(exp_q_data.pop_front());
      end
      if (keep) begin exp_q_pc.push_back(m); exp_q_data.push_back(mem_word(m)); end
      if (obs_fire) begin
        due = cyc + lat_min + int'($urandom_range(lat_max - lat_min));
        if (due < last_due) due = last_due;
        last_due = due;
        pend_addr.push_back(obs_addr); pend_mpc.push_back(next_addr);
        pend_ep.push_back(cur_ep); pend_due.push_back(due);
      end
      if (redirect_valid) begin
        cur_ep++; exp_q_pc.delete(); exp_q_data.delete();
        next_addr = {redirect_pc[31:2], 2'b00};
      end else if (obs_fire) begin
        next_addr = next_addr + 32'd4;
      end
      mis_pend  = redirect_valid && (redirect_pc[1:0] != 2'b00);
      prev_halt = halt;
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1; halt = 1'b0; redirect_valid = 1'b0; instr_ready = 1'b1;
    p_ready = 100; lat_min = 1; lat_max = 1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; halt = 1'b0; redirect_valid = 1'b0; instr_ready = 1'b1;
    step(); step();
    checks++; if (obs_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b expected 0", obs_req_valid); end
    checks++; if (obs_ivalid !== 1'b0) begin errors++; $display("FAIL reset_instr_valid: got %b expected 0", obs_ivalid); end
    checks++; if (obs_mis !== 1'b0) begin errors++; $display("FAIL reset_misaligned: got %b expected 0", obs_mis); end
    checks++; if (obs_instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h expected 0", obs_instr); end
    checks++; if (obs_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 0", obs_pc); end
    rst = 1'b0;
  endtask

  task automatic test_sequential();
    int nfire, npop, first_v;
    logic [31:0] e;
    nfire = 0; npop = 0; first_v = -1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (i == 0) begin
        checks++;
        if (obs_req_valid !== 1'b1 || obs_addr !== RST_PC) begin
          errors++; $display("FAIL seq_first_req: got v=%b addr=%h expected v=1 addr=%h", obs_req_valid, obs_addr, RST_PC);
        end
      end
      checks++;
      if (obs_req_valid !== exp_req_valid) begin errors++; $display("FAIL seq_req_valid cyc %0d: got %b expected %b", i, obs_req_valid, exp_req_valid); end
      if (obs_fire) begin
        e = RST_PC + 32'(nfire) * 32'd4;
        if (nfire < 3) begin
          checks++; if (obs_addr !== e) begin errors++; $display("FAIL seq_addr: got %h expected %h", obs_addr, e); end
        end
        nfire++;
      end
      if (obs_ivalid && first_v < 0) first_v = i;
      if (obs_pop) begin
        e = RST_PC + 32'(npop) * 32'd4;
        if (npop < 3) begin
          checks++; if (obs_pc !== e || obs_instr !== mem_word(e)) begin
            errors++; $display("FAIL seq_pop: got pc=%h instr=%h expected pc=%h instr=%h", obs_pc, obs_instr, e, mem_word(e));
          end
        end
        npop++;
      end
    end
    checks++; if (first_v != 2) begin errors++; $display("FAIL seq_first_valid_cycle: got %0d expected 2", first_v); end
    checks++; if (npop < 3) begin errors++; $display("FAIL seq_pop_count: got %0d expected >=3", npop); end
  endtask

  task automatic test_backpressure();
    int nfire, npop;
    logic [31:0] e;
    do_reset();
    instr_ready = 1'b0; nfire = 0;
    for (int i = 0; i < 8; i++) begin step(); if (obs_fire) nfire++; end
    checks++; if (nfire != DEPTH) begin errors++; $display("FAIL bp_req_count: got %0d expected %0d", nfire, DEPTH); end
    checks++; if (obs_req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_valid: got %b expected 0", obs_req_valid); end
    checks++; if (obs_ivalid !== 1'b1 || obs_pc !== RST_PC) begin errors++; $display("FAIL bp_head: got v=%b pc=%h expected v=1 pc=%h", obs_ivalid, obs_pc, RST_PC); end
    instr_ready = 1'b1; npop = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (obs_fire) nfire++;
      if (obs_pop) begin
        e = RST_PC + 32'(npop) * 32'd4;
        if (npop < 3) begin
          checks++; if (obs_pc !== e) begin errors++; $display("FAIL bp_order: got %h expected %h", obs_pc, e); end
        end
        npop++;
      end
    end
    checks++; if (nfire <= DEPTH) begin errors++; $display("FAIL bp_resume: got %0d requests expected >%0d", nfire, DEPTH); end
    checks++; if (npop < 3) begin errors++; $display("FAIL bp_pop_count: got %0d expected >=3", npop); end
  endtask

  task automatic test_redirect_drop();
    int nfire, nf2;
    logic found;
    logic [31:0] e;
    do_reset();
    lat_min = 3; lat_max = 3;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200; step(); redirect_valid = 1'b0;
    nfire = 0;
    for (int i = 0; i < 10 && nfire < 2; i++) begin
      step();
      if (obs_fire) begin
        e = 32'h0000_0200 + 32'(nfire) * 32'd4;
        checks++; if (obs_addr !== e) begin errors++; $display("FAIL rd_old_addr: got %h expected %h", obs_addr, e); end
        nfire++;
      end
    end
    checks++; if (nfire != 2) begin errors++; $display("FAIL rd_inflight: got %0d requests expected 2", nfire); end
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0400; step(); redirect_valid = 1'b0;
    checks++; if (obs_req_valid !== 1'b0) begin errors++; $display("FAIL rd_no_issue: got %b expected 0", obs_req_valid); end
    found = 1'b0; nf2 = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (obs_fire && nf2 == 0) begin
        nf2++;
        checks++; if (obs_addr !== 32'h0000_0400) begin errors++; $display("FAIL rd_new_addr: got %h expected 00000400", obs_addr); end
      end
      if (obs_ivalid) begin
        found = 1'b1;
        checks++; if (obs_pc !== 32'h0000_0400 || obs_instr !== mem_word(32'h0000_0400)) begin
          errors++; $display("FAIL rd_first_instr: got pc=%h instr=%h expected pc=00000400 instr=%h", obs_pc, obs_instr, mem_word(32'h0000_0400));
        end
      end
    end
    checks++; if (!found) begin errors++; $display("FAIL rd_timeout: got no instr expected pc 00000400"); end
  endtask

  task automatic test_halt();
    int nfire, got;
    logic found;
    do_reset();
    lat_min = 3; lat_max = 3;
    step();
    checks++; if (!obs_fire || obs_addr !== RST_PC) begin errors++; $display("FAIL halt_first_req: got fire=%b addr=%h expected 1 %h", obs_fire, obs_addr, RST_PC); end
    halt = 1'b1; nfire = 0; got = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (obs_fire) nfire++;
      if (obs_pop) begin
        got++;
        checks++; if (obs_pc !== RST_PC || obs_instr !== mem_word(RST_PC)) begin
          errors++; $display("FAIL halt_delivery: got pc=%h instr=%h expected pc=%h instr=%h", obs_pc, obs_instr, RST_PC, mem_word(RST_PC));
        end
      end
    end
    checks++; if (nfire != 0) begin errors++; $display("FAIL halt_no_req: got %0d requests expected 0", nfire); end
    checks++; if (got != 1) begin errors++; $display("FAIL halt_pop_count: got %0d expected 1", got); end
    halt = 1'b0; found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      step();
      if (obs_fire) begin
        found = 1'b1;
        checks++; if (obs_addr !== RST_PC + 32'd4) begin errors++; $display("FAIL halt_resume_addr: got %h expected %h", obs_addr, RST_PC + 32'd4); end
      end
    end
    checks++; if (!found) begin errors++; $display("FAIL halt_resume_timeout: got no request expected %h", RST_PC + 32'd4); end
  endtask

  task automatic test_misaligned();
    do_reset();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0402; step(); redirect_valid = 1'b0;
    checks++; if (obs_req_valid !== 1'b0 || obs_mis !== 1'b0) begin errors++; $display("FAIL mis_redirect_cycle: got req=%b mis=%b expected 0 0", obs_req_valid, obs_mis); end
    step();
    checks++; if (obs_mis !== 1'b1) begin errors++; $display("FAIL mis_pulse: got %b expected 1", obs_mis); end
    checks++; if (obs_req_valid !== 1'b1 || obs_addr !== 32'h0000_0400) begin errors++; $display("FAIL mis_addr: got v=%b addr=%h expected v=1 addr=00000400", obs_req_valid, obs_addr); end
    step();
    checks++; if (obs_mis !== 1'b0) begin errors++; $display("FAIL mis_one_cycle: got %b expected 0", obs_mis); end
  endtask

  task automatic test_wrap();
    int nfire, npop;
    logic [31:0] e;
    do_reset();
    redirect_valid = 1'b1; redirect_pc = WRAP_PC; step(); redirect_valid = 1'b0;
    nfire = 0; npop = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (obs_fire) begin
        e = WRAP_PC + 32'(nfire) * 32'd4;
        if (nfire < 2) begin
          checks++; if (obs_addr !== e) begin errors++; $display("FAIL wrap_addr: got %h expected %h", obs_addr, e); end
        end
        nfire++;
      end
      if (obs_pop) begin
        e = WRAP_PC + 32'(npop) * 32'd4;
        if (npop < 2) begin
          checks++; if (obs_pc !== e || obs_instr !== mem_word(e)) begin
            errors++; $display("FAIL wrap_pop: got pc=%h instr=%h expected pc=%h instr=%h", obs_pc, obs_instr, e, mem_word(e));
          end
        end
        npop++;
      end
    end
    checks++; if (npop < 2) begin errors++; $display("FAIL wrap_pop_count: got %0d expected >=2", npop); end
  endtask

  task automatic test_random();
    do_reset();
    p_ready = 70; lat_min = 1; lat_max = 3;
    for (int i = 0; i < 3000; i++) begin
      rst = (int'($urandom_range(199)) == 0);
      if (int'($urandom_range(99)) < 10) halt = ~halt;
      instr_ready    = (int'($urandom_range(99)) < 75);
      redirect_valid = (int'($urandom_range(99)) < 6);
      case ($urandom_range(2))
        0:       redirect_pc = $urandom;
        1:       redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(15));
        default: redirect_pc = 32'h0000_1000 + 32'($urandom_range(63));
      endcase
      step();
      checks++;
      if (obs_req_valid !== exp_req_valid) begin errors++; $display("FAIL rand_req_valid cyc %0d: got %b expected %b", cyc, obs_req_valid, exp_req_valid); end
      if (exp_req_valid) begin
        checks++; if (obs_addr !== exp_addr) begin errors++; $display("FAIL rand_addr cyc %0d: got %h expected %h", cyc, obs_addr, exp_addr); end
      end
      checks++;
      if (obs_ivalid !== exp_ivalid) begin errors++; $display("FAIL rand_instr_valid cyc %0d: got %b expected %b", cyc, obs_ivalid, exp_ivalid); end
      if (exp_ivalid) begin
        checks++; if (obs_pc !== exp_pc || obs_instr !== exp_instr) begin
          errors++; $display("FAIL rand_head cyc %0d: got pc=%h instr=%h expected pc=%h instr=%h", cyc, obs_pc, obs_instr, exp_pc, exp_instr);
        end
      end
      checks++;
      if (obs_mis !== exp_mis) begin errors++; $display("FAIL rand_misaligned cyc %0d: got %b expected %b", cyc, obs_mis, exp_mis); end
    end
    rst = 1'b0; halt = 1'b0; redirect_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_drop();
    test_halt();
    test_misaligned();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
